// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding uart_tx over its ready/data/data_strobe handshake.
// Optional build macro UART_TX_FIFO_CRLF_EN: expands each stored LF into a CR, LF pair
// on the output side; when undefined, bytes pass through verbatim.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_strobe,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  uart_ready,
  output logic [WIDTH-1:0]      uart_data,
  output logic                  uart_strobe
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;
  logic [WIDTH-1:0] r_data;
  logic             r_strobe;

  logic             w_wr_acc;
  logic             w_pop;
  logic             w_adv;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_issue_data;
  logic [CW-1:0]    w_count_nxt;

  // Accept/issue decisions use only registered state, never a same-cycle bypass
  assign w_wr_acc = wr_strobe & ~r_full;
  assign w_pop    = uart_ready & ~r_strobe & ~r_empty;
  assign w_head   = r_mem[r_rd_ptr];

`ifdef UART_TX_FIFO_CRLF_EN
  localparam logic [WIDTH-1:0] LF = WIDTH'(8'h0A);
  localparam logic [WIDTH-1:0] CR = WIDTH'(8'h0D);

  logic r_cr_sent;
  logic w_send_cr;

  // An LF at the head is first issued as CR without consuming the entry
  assign w_send_cr    = w_pop & (w_head == LF) & ~r_cr_sent;
  assign w_adv        = w_pop & ~w_send_cr;
  assign w_issue_data = w_send_cr ? CR : w_head;

  // Remembers that the CR for the current head LF has gone out
  always_ff @(posedge mclk) begin
    if (!reset) begin
      r_cr_sent <= 1'b0;
    end else if (w_send_cr) begin
      r_cr_sent <= 1'b1;
    end else if (w_adv) begin
      r_cr_sent <= 1'b0;
    end
  end
`else
  assign w_adv        = w_pop;
  assign w_issue_data = w_head;
`endif

  // Occupancy after this edge: counts stored entries only
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_adv})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; contents are invalidated by pointer reset, not cleared
  always_ff @(posedge mclk) begin
    if (reset && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, flags and sticky overflow
  always_ff @(posedge mclk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_adv) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (wr_strobe && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Output handshake: one-cycle strobe, data held between strobes
  always_ff @(posedge mclk) begin
    if (!reset) begin
      r_strobe <= 1'b0;
      r_data   <= '0;
    end else begin
      r_strobe <= w_pop;
      if (w_pop) begin
        r_data <= w_issue_data;
      end
    end
  end

  assign full        = r_full;
  assign empty       = r_empty;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign uart_data   = r_data;
  assign uart_strobe = r_strobe;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared every cycle,
// plus literal expectations on output byte sequences and flags.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       mclk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       uart_ready;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] uart_data;
  logic       uart_strobe;

  int checks;
  int errors;
  int cyc;
  int last_wr_cyc;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_strobe;
  logic [7:0] m_data;
  logic       m_ovf;
`ifdef UART_TX_FIFO_CRLF_EN
  logic       m_cr;
`endif

  // Observed output stream
  logic [7:0] out_log[$];
  int         out_cyc[$];

  uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .mclk        (mclk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_strobe   (wr_strobe),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .uart_ready  (uart_ready),
    .uart_data   (uart_data),
    .uart_strobe (uart_strobe)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of stored bytes; one issue per ready cycle with an idle cycle after each
  always @(posedge mclk) begin
    bit was_full;
    bit was_empty;
    bit pop;
    if (!reset) begin
      mq.delete();
      m_strobe = 1'b0;
      m_data   = 8'h00;
      m_ovf    = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
      m_cr     = 1'b0;
`endif
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      pop       = uart_ready && !m_strobe && !was_empty;
      m_strobe  = pop;
      if (pop) begin
`ifdef UART_TX_FIFO_CRLF_EN
        if (mq[0] == 8'h0A && !m_cr) begin
          m_data = 8'h0D;
          m_cr   = 1'b1;
        end else begin
          m_data = mq.pop_front();
          m_cr   = 1'b0;
        end
`else
        m_data = mq.pop_front();
`endif
      end
      if (wr_strobe) begin
        if (was_full) m_ovf = 1'b1;
        else          mq.push_back(wr_data);
      end
    end
  end

  // Per-cycle comparison against the model, and output stream capture
  always @(posedge mclk) begin
    #1;
    cyc++;
    check("uart_strobe", 32'(uart_strobe), 32'(m_strobe));
    check("uart_data",   32'(uart_data),   32'(m_data));
    check("count",       32'(count),       32'(mq.size()));
    check("full",        32'(full),        32'(mq.size() == DEPTH));
    check("empty",       32'(empty),       32'(mq.size() == 0));
    check("overflow",    32'(overflow),    32'(m_ovf));
    if (uart_strobe) begin
      out_log.push_back(uart_data);
      out_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    reset = 1'b0;
    @(negedge mclk);
    reset = 1'b1;
  endtask

  // Drive one write; back-to-back calls give consecutive-cycle writes
  task automatic send(input logic [7:0] b);
    @(negedge mclk);
    wr_data   = b;
    wr_strobe = 1'b1;
    @(posedge mclk);
    last_wr_cyc = cyc + 1;
  endtask

  task automatic stop_wr();
    @(negedge mclk);
    wr_strobe = 1'b0;
  endtask

  task automatic clear_log();
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(out_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < out_log.size()) check($sformatf("%s_byte%0d", name, i), 32'(out_log[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] exp[$];
    int first_wr;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    last_wr_cyc = 0;
    reset       = 1'b0;
    wr_data     = 8'h00;
    wr_strobe   = 1'b0;
    uart_ready  = 1'b1;

    // Reset then idle with sink ready
    idle(3);
    reset = 1'b1;
    clear_log();
    idle(8);
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_count", 32'(count), 32'd0);
    check("idle_ovf",   32'(overflow), 32'd0);
    check("idle_no_strobe", 32'(out_log.size()), 32'd0);

    // Three consecutive writes
    clear_log();
    send(8'h41);
    first_wr = last_wr_cyc;
    send(8'h42);
    send(8'h43);
    stop_wr();
    idle(12);
    exp = '{8'h41, 8'h42, 8'h43};
    check_log("abc", exp);
    if (out_cyc.size() >= 3) begin
      check("abc_latency", 32'(out_cyc[0] - first_wr), 32'd1);
      check("abc_gap01", 32'(out_cyc[1] - out_cyc[0] >= 2), 32'd1);
      check("abc_gap12", 32'(out_cyc[2] - out_cyc[1] >= 2), 32'd1);
    end

    // Fill with sink stalled, overflow on the 17th write, then drain
    do_reset();
    uart_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 17; i++) send(8'(i));
    stop_wr();
    idle(2);
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovf",   32'(overflow), 32'd1);
    uart_ready = 1'b1;
    idle(40);
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'(i));
    check_log("drain", exp);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Continuous writes with popping sink; pointers wrap
    do_reset();
    clear_log();
    for (int i = 0; i < 20; i++) send(8'h80 + 8'(i));
    stop_wr();
    idle(50);
    exp.delete();
    for (int i = 0; i < 20; i++) exp.push_back(8'h80 + 8'(i));
    check_log("wrap", exp);
    check("wrap_ovf", 32'(overflow), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset with entries queued discards them
    do_reset();
    uart_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h60 + 8'(i));
    stop_wr();
    idle(1);
    check("queued_count", 32'(count), 32'd5);
    @(negedge mclk);
    reset = 1'b0;
    @(posedge mclk);
    #2;
    check("rst_count",  32'(count), 32'd0);
    check("rst_empty",  32'(empty), 32'd1);
    check("rst_strobe", 32'(uart_strobe), 32'd0);
    @(negedge mclk);
    reset      = 1'b1;
    uart_ready = 1'b1;
    clear_log();
    idle(10);
    check("rst_no_stale", 32'(out_log.size()), 32'd0);

    // Line feed handling
    do_reset();
    clear_log();
    send(8'h41);
    send(8'h0A);
    send(8'h42);
    stop_wr();
    idle(20);
`ifdef UART_TX_FIFO_CRLF_EN
    exp = '{8'h41, 8'h0D, 8'h0A, 8'h42};
`else
    exp = '{8'h41, 8'h0A, 8'h42};
`endif
    check_log("lf", exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO that sits directly upstream of uart_tx. It buffers bytes written by producer logic at mclk rate and feeds them one at a time over uart_tx's ready / data / data_strobe handshake. Producers no longer poll uart ready or throttle with counter masks; they check `full` and write. Instantiated in top-level designs between message-generation logic and uart_tx.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2^DEPTH_LOG2 entries (16 by default)
WIDTH, 8, data width in bits; must match uart_tx data width

Ports:
mclk  input  1  system clock (48 MHz HFOSC domain)
reset  input  1  synchronous reset, active-low; 0 = reset, sampled on posedge mclk
wr_data  input  WIDTH  byte to enqueue
wr_strobe  input  1  single-cycle enqueue request
full  output  1  FIFO holds 2^DEPTH_LOG2 entries
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
overflow  output  1  sticky; set when a write is dropped
uart_ready  input  1  from uart_tx.ready
uart_data  output  WIDTH  to uart_tx.data
uart_strobe  output  1  to uart_tx.data_strobe

Behaviour:
- One clock (mclk), one reset; reset is synchronous and active-low. All state updates on posedge mclk.
- Reset (reset==0) values: rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0, uart_strobe = 0, uart_data = 0.
- Reset mid-transfer: the FIFO contents are discarded. A byte already strobed into uart_tx is uart_tx's responsibility.
- Storage: 2^DEPTH_LOG2 x WIDTH register array.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- count is a separate DEPTH_LOG2+1-bit counter. full = (count == 2^DEPTH_LOG2); empty = (count == 0). Both are registered-derived, with no combinational path from wr_strobe.
- Write acceptance: a write is accepted when wr_strobe=1 and full=0. On acceptance, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Write while full: the byte is dropped, pointers are unchanged, and overflow <= 1. overflow stays set until reset. This holds even if a pop happens in the same cycle; the full check uses the pre-cycle count.
- Pop/issue condition: uart_ready=1 and uart_strobe=0 and empty=0.
- On pop, in the same edge: uart_data <= mem[rd_ptr], uart_strobe <= 1, rd_ptr increments.
- uart_strobe is high for exactly one cycle and is cleared the next cycle.
- Minimum spacing is one idle cycle between strobes. This covers uart_tx dropping ready one cycle late.
- Latency: a byte written into an empty FIFO with uart_ready=1 produces uart_strobe 1 cycle after the write edge.
- uart_data holds its last value between strobes.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- Write to an empty FIFO does not bypass the FIFO: a byte is never issued in the same cycle it is written.
- Ordering: strictly FIFO; no reordering or duplication.

Optional Feature:
Macro UART_TX_FIFO_CRLF_EN.
- Defined: when the popped entry equals 8'h0A, the block first issues 8'h0D and leaves the entry in place (rd_ptr not advanced). A one-bit state cr_sent is then set. The next eligible issue sends 8'h0A, advances rd_ptr and clears cr_sent.
- Defined: count and full reflect stored entries only. reset clears cr_sent. An 8'h0D already present in the stream is passed through unchanged.
- Undefined: no translation; bytes are passed through verbatim and cr_sent logic is absent.

Test Plan:
- Reset then idle with uart_ready=1 -> uart_strobe never asserts; empty=1, count=0, overflow=0.
- Write 8'h41, 8'h42, 8'h43 on consecutive cycles, uart_ready=1 -> three strobes with data 41, 42, 43 in order, at least one idle cycle apart; first strobe 1 cycle after the first write.
- Hold uart_ready=0 and write 17 bytes 00..10 with DEPTH_LOG2=4 -> full=1 after 16 writes, byte 10 dropped, overflow=1. Then raise uart_ready -> output is 00..0F and empty=1 at the end.
- Write 20 bytes while the sink pops continuously -> pointer wrap-around is exercised; output order is exact and overflow=0.
- Assert reset=0 for one cycle with 5 entries queued -> count=0, empty=1, uart_strobe=0 next cycle; no stale bytes issued afterwards.
- With UART_TX_FIFO_CRLF_EN defined, write "A", 8'h0A, "B" -> output sequence 41, 0D, 0A, 42. With the macro undefined, the output is 41, 0A, 42.
